mesh_boot_loader: RTL and testbench
===================================

Name: mesh_boot_loader

Overview:
- Parametrised boot controller for an N-processor mesh; replaces the fixed 9-way hard-coded select decode.
- Accepts a load command (target processor or broadcast, instruction and data word counts), then streams host words into instruction then data memory of the target(s) with auto-incrementing addresses.
- Releases loaded processors from reset individually.
- Sits between the host boot port and the boot_i*/boot_d* pins of every system instance.

Parameters:
- NUM_PROCS, 9, number of processors in the mesh (1..64)
- SEL_W, 6, width of proc_sel; must satisfy 2**SEL_W > NUM_PROCS
- ADDR_W, 14, boot address width (word addresses)
- DATA_W, 32, boot data width
- LEN_W, 15, width of length fields; must be able to hold 2**ADDR_W

Ports:
- clk  in  1  clock
- reset  in  1  one clock; reset is synchronous and active-high
- cmd_valid  in  1  load command present
- cmd_ready  out  1  high only in IDLE
- cmd_sel  in  SEL_W  target processor index
- cmd_bcast  in  1  load all processors; cmd_sel is ignored
- cmd_ilen  in  LEN_W  instruction word count
- cmd_dlen  in  LEN_W  data word count
- wd_valid  in  1  host word valid
- wd_ready  out  1  high in LOAD_I and LOAD_D
- wd_data  in  DATA_W  host word
- boot_iaddr  out  ADDR_W  instruction write address
- boot_idata  out  DATA_W  instruction write data
- boot_iwe  out  NUM_PROCS  per-processor instruction write enable
- boot_daddr  out  ADDR_W  data write address
- boot_ddata  out  DATA_W  data write data
- boot_dwe  out  NUM_PROCS  per-processor data write enable
- proc_run  out  NUM_PROCS  per-processor run enable (active-low reset to the processor)
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse when a load completes
- cmd_err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset values: all outputs 0 (boot_iwe, boot_dwe, proc_run, busy, done, cmd_err, addresses, data). State goes to IDLE.
- Reset mid-load aborts immediately:
  - no further write enables;
  - all proc_run cleared, so every processor is held in reset.
- FSM states and transitions:
  - IDLE: cmd_ready=1. A command is accepted on cmd_valid && cmd_ready.
  - On acceptance, compute target mask:
    - broadcast: all NUM_PROCS bits set;
    - otherwise: one-hot of cmd_sel.
  - Also on acceptance: latch ilen/dlen, clear proc_run bits in the mask, reset the address counter to 0.
  - Next state: LOAD_I if ilen≠0, else LOAD_D if dlen≠0, else RELEASE.
  - Rejected command: cmd_sel ≥ NUM_PROCS with cmd_bcast=0. The command is consumed, cmd_err pulses the next cycle, state stays IDLE, and proc_run is unchanged.
  - LOAD_I: each accepted word (wd_valid && wd_ready) is registered. Next cycle: boot_iaddr = counter, boot_idata = word, boot_iwe = mask. The counter then increments.
  - After the ilen-th word: go to LOAD_D if dlen≠0, else RELEASE. The counter resets to 0 on the transition.
  - LOAD_D: same as LOAD_I, using the boot_d* outputs and dlen.
  - RELEASE: lasts one cycle. proc_run |= mask; done pulses; return to IDLE.
- Write enables are asserted for exactly one cycle per accepted word. Latency from accept to write is 1 cycle.
- No write enable is ever asserted when no word was accepted (wd_valid low stalls the load, with no gaps written).
- boot_iwe and boot_dwe are never asserted in the same cycle.
- Address wrap: when the count exceeds 2**ADDR_W, the address wraps modulo 2**ADDR_W (lengths above 2**ADDR_W are legal but overwrite). Counters are LEN_W wide; address = counter[ADDR_W-1:0].
- Back-to-back words:
  - wd_ready stays high through the last word of a phase.
  - wd_ready is low during the RELEASE cycle and during the cycle between LOAD_I and LOAD_D.
- Processors not in the mask keep their proc_run value and see no write enables.
- The last write of a phase is issued before proc_run rises. proc_run for a target rises no earlier than 1 cycle after its last write enable.

Decomposition:
- Shared package mesh_boot_pkg holds:
  - state enum (IDLE, LOAD_I, LOAD_D, RELEASE);
  - default parameter constants;
  - a function for sel→one-hot mask with range check.
- One sub-module: mesh_boot_wr_stage, the registered address counter plus data/enable output stage, instantiated twice (instruction and data ports).

Test Plan:
- Single load: sel=4, ilen=3, dlen=2, words A0..A4 with no stalls.
  - boot_iwe=9'h010 at addresses 0,1,2 with A0..A2;
  - then boot_dwe=9'h010 at addresses 0,1 with A3,A4;
  - done pulse; proc_run=9'h010.
- Broadcast: bcast=1, ilen=1, dlen=0, word 0xDEADBEEF.
  - boot_iwe=9'h1FF at addr 0 for one cycle; no boot_dwe;
  - proc_run=9'h1FF.
- Stalls and edge lengths:
  - wd_valid toggled 1/0 during ilen=4: exactly 4 write pulses, contiguous addresses 0..3, no write in stall cycles.
  - ilen=0, dlen=0: no writes; done 2 cycles after acceptance.
- Bad select: sel=9 with NUM_PROCS=9.
  - cmd_err pulses; no writes; proc_run unchanged; cmd_ready high again next cycle.
- Reset mid-load: assert reset during LOAD_D, word 1 of 4.
  - Next cycle: all we=0, proc_run=0, busy=0.
  - A new command is accepted after reset is released.
- Reload and wrap: reload proc 2 while proc 4 is running.
  - proc_run[2] drops at acceptance, proc_run[4] stays 1.
  - With ADDR_W=2 and ilen=5: fifth write lands at addr 0.

Source files
------------

// File: rtl/mesh_boot_pkg.sv
// Shared definitions for the mesh boot loader.
//   state_e      : loader FSM states
//   DEF_*        : default parameter values used by the loader and its write stage
//   sel_to_mask  : processor index -> one-hot target mask; all-zero when the
//                  index is outside the populated mesh
package mesh_boot_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_I  = 2'd1,
    LOAD_D  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int MAX_PROCS     = 64;
  localparam int DEF_NUM_PROCS = 9;
  localparam int DEF_SEL_W     = 6;
  localparam int DEF_ADDR_W    = 14;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_LEN_W     = 15;

  // An all-zero result doubles as the "out of range" indication.
  function automatic logic [MAX_PROCS-1:0] sel_to_mask(input int unsigned sel,
                                                        input int unsigned num_procs);
    logic [MAX_PROCS-1:0] m;
    m = '0;
    if (sel < num_procs) m[sel[5:0]] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mesh_boot_wr_stage.sv
// Boot write port stage: word counter plus registered address/data/enable.
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart the word counter at 0
//   wr         : a host word was accepted for this port this cycle
//   wr_data    : the accepted word
//   mask       : processors targeted by the current load
//   cnt        : words written so far in this phase
//   addr/data  : registered write address and data
//   we         : registered per-processor write enable (one cycle per word)
module mesh_boot_wr_stage
  import mesh_boot_pkg::*;
#(
  parameter int NUM_PROCS = DEF_NUM_PROCS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 wr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [NUM_PROCS-1:0] mask,
  output logic [LEN_W-1:0]     cnt,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    data,
  output logic [NUM_PROCS-1:0] we
);

  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [NUM_PROCS-1:0] we_q, we_d;

  // The address is the low bits of the counter, so long loads wrap.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    we_d   = '0;
    if (clr) begin
      cnt_d = '0;
    end else if (wr) begin
      addr_d = cnt_q[ADDR_W-1:0];
      data_d = wr_data;
      we_d   = mask;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
    end
  end

  assign cnt  = cnt_q;
  assign addr = addr_q;
  assign data = data_q;
  assign we   = we_q;

endmodule

// File: rtl/mesh_boot_loader.sv
// Boot controller for an N-processor mesh.
// Takes a load command (one processor or broadcast, instruction/data word
// counts), streams host words into the instruction then data memories of the
// targets, then releases the targets from reset.
//   cmd_*      : load command handshake and fields
//   wd_*       : host word stream handshake
//   boot_i*    : instruction memory write port (shared addr/data, per-proc we)
//   boot_d*    : data memory write port
//   proc_run   : per-processor run enable (low holds the processor in reset)
//   busy       : loader not idle
//   done       : one-cycle pulse when a load completes
//   cmd_err    : one-cycle pulse when a command names a missing processor
module mesh_boot_loader
  import mesh_boot_pkg::*;
#(
  parameter int NUM_PROCS = DEF_NUM_PROCS,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [SEL_W-1:0]     cmd_sel,
  input  logic                 cmd_bcast,
  input  logic [LEN_W-1:0]     cmd_ilen,
  input  logic [LEN_W-1:0]     cmd_dlen,
  input  logic                 wd_valid,
  output logic                 wd_ready,
  input  logic [DATA_W-1:0]    wd_data,
  output logic [ADDR_W-1:0]    boot_iaddr,
  output logic [DATA_W-1:0]    boot_idata,
  output logic [NUM_PROCS-1:0] boot_iwe,
  output logic [ADDR_W-1:0]    boot_daddr,
  output logic [DATA_W-1:0]    boot_ddata,
  output logic [NUM_PROCS-1:0] boot_dwe,
  output logic [NUM_PROCS-1:0] proc_run,
  output logic                 busy,
  output logic                 done,
  output logic                 cmd_err
);

  state_e               state_q, state_d;
  logic [NUM_PROCS-1:0] mask_q, mask_d;
  logic [LEN_W-1:0]     ilen_q, ilen_d;
  logic [LEN_W-1:0]     dlen_q, dlen_d;
  logic [NUM_PROCS-1:0] run_q, run_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 gap_q, gap_d;

  logic                 cmd_fire, wd_fire, i_wr, d_wr, i_last, d_last, clr;
  logic                 sel_ok;
  logic [NUM_PROCS-1:0] cmd_mask;
  logic [LEN_W-1:0]     icnt, dcnt;

  assign cmd_ready = (state_q == IDLE);
  // gap_q holds off the first data word for one cycle after the instruction
  // phase, keeping a dead cycle between the two phases.
  assign wd_ready  = (state_q == LOAD_I) || ((state_q == LOAD_D) && !gap_q);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign cmd_err   = err_q;
  assign proc_run  = run_q;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign wd_fire  = wd_valid && wd_ready;
  assign i_wr     = wd_fire && (state_q == LOAD_I);
  assign d_wr     = wd_fire && (state_q == LOAD_D);
  assign i_last   = i_wr && (icnt == ilen_q - 1'b1);
  assign d_last   = d_wr && (dlen_q != '0) && (dcnt == dlen_q - 1'b1);

  // Truncating the 64-bit one-hot keeps only populated processors; an
  // out-of-range index leaves an all-zero mask.
  assign cmd_mask = cmd_bcast ? '1
                  : NUM_PROCS'(sel_to_mask(32'(cmd_sel), NUM_PROCS));
  assign sel_ok   = cmd_bcast || (cmd_mask != '0);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ilen_d  = ilen_q;
    dlen_d  = dlen_q;
    run_d   = run_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    gap_d   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (!sel_ok) begin
            err_d = 1'b1;
          end else begin
            mask_d  = cmd_mask;
            ilen_d  = cmd_ilen;
            dlen_d  = cmd_dlen;
            run_d   = run_q & ~cmd_mask;
            clr     = 1'b1;
            state_d = (cmd_ilen != '0) ? LOAD_I
                    : (cmd_dlen != '0) ? LOAD_D : RELEASE;
          end
        end
      end
      LOAD_I: begin
        if (i_last) begin
          if (dlen_q != '0) begin
            state_d = LOAD_D;
            gap_d   = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      LOAD_D: begin
        if (d_last) state_d = RELEASE;
      end
      RELEASE: begin
        // The last write enable is on the outputs this cycle; run rises next.
        run_d   = run_q | mask_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      ilen_q  <= '0;
      dlen_q  <= '0;
      run_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ilen_q  <= ilen_d;
      dlen_q  <= dlen_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
    end
  end

  mesh_boot_wr_stage #(
    .NUM_PROCS(NUM_PROCS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) u_istage (
    .clk(clk), .reset(reset), .clr(clr), .wr(i_wr), .wr_data(wd_data),
    .mask(mask_q), .cnt(icnt), .addr(boot_iaddr), .data(boot_idata),
    .we(boot_iwe)
  );

  mesh_boot_wr_stage #(
    .NUM_PROCS(NUM_PROCS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) u_dstage (
    .clk(clk), .reset(reset), .clr(clr), .wr(d_wr), .wr_data(wd_data),
    .mask(mask_q), .cnt(dcnt), .addr(boot_daddr), .data(boot_ddata),
    .we(boot_dwe)
  );

endmodule

// File: tb/tb_mesh_boot_loader.sv
// Directed bench for mesh_boot_loader: a default-sized instance for the main
// sequence and a small-address instance for address wrap.
module tb_mesh_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_bcast, wd_valid;
  logic [5:0]  cmd_sel;
  logic [14:0] cmd_ilen, cmd_dlen;
  logic [31:0] wd_data;
  logic        cmd_ready, wd_ready, busy, done, cmd_err;
  logic [13:0] boot_iaddr, boot_daddr;
  logic [31:0] boot_idata, boot_ddata;
  logic [8:0]  boot_iwe, boot_dwe, proc_run;

  // Wrap instance (ADDR_W=2, LEN_W=4)
  logic        c2_valid, c2_bcast, w2_valid;
  logic [5:0]  c2_sel;
  logic [3:0]  c2_ilen, c2_dlen;
  logic [31:0] w2_data;
  logic        c2_ready, w2_ready, busy2, done2, err2;
  logic [1:0]  iaddr2, daddr2;
  logic [31:0] idata2, ddata2;
  logic [8:0]  iwe2, dwe2, run2;

  int checks = 0;
  int errors = 0;
  int ipulses = 0, dpulses = 0, overlaps = 0;
  int n2 = 0;
  logic [1:0] a2 [0:7];

  always #5 clk = ~clk;

  mesh_boot_loader dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_bcast(cmd_bcast), .cmd_ilen(cmd_ilen),
    .cmd_dlen(cmd_dlen), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .wd_data(wd_data), .boot_iaddr(boot_iaddr), .boot_idata(boot_idata),
    .boot_iwe(boot_iwe), .boot_daddr(boot_daddr), .boot_ddata(boot_ddata),
    .boot_dwe(boot_dwe), .proc_run(proc_run), .busy(busy), .done(done),
    .cmd_err(cmd_err)
  );

  mesh_boot_loader #(.ADDR_W(2), .LEN_W(4)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
    .cmd_sel(c2_sel), .cmd_bcast(c2_bcast), .cmd_ilen(c2_ilen),
    .cmd_dlen(c2_dlen), .wd_valid(w2_valid), .wd_ready(w2_ready),
    .wd_data(w2_data), .boot_iaddr(iaddr2), .boot_idata(idata2),
    .boot_iwe(iwe2), .boot_daddr(daddr2), .boot_ddata(ddata2),
    .boot_dwe(dwe2), .proc_run(run2), .busy(busy2), .done(done2),
    .cmd_err(err2)
  );

  always @(negedge clk) begin
    if (boot_iwe != '0) ipulses <= ipulses + 1;
    if (boot_dwe != '0) dpulses <= dpulses + 1;
    if ((boot_iwe != '0) && (boot_dwe != '0)) overlaps <= overlaps + 1;
    if ((iwe2 != '0) && (n2 < 8)) begin
      a2[n2] <= iaddr2;
      n2     <= n2 + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [5:0] sel, input logic bc,
                        input logic [14:0] il, input logic [14:0] dl);
    int n = 0;
    cmd_valid = 1'b1; cmd_sel = sel; cmd_bcast = bc; cmd_ilen = il; cmd_dlen = dl;
    while (!cmd_ready && n < 16) begin @(posedge clk); #1; n++; end
    if (n >= 16) chk("cmd_ready timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Leaves wd_valid high so consecutive pushes stream without gaps.
  task automatic push(input logic [31:0] d);
    int n = 0;
    wd_valid = 1'b1; wd_data = d;
    while (!wd_ready && n < 16) begin @(posedge clk); #1; n++; end
    if (n >= 16) chk("wd_ready timeout", 64'(wd_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 16) begin @(posedge clk); #1; n++; end
    chk("done seen", 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ip0, dp0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_bcast = 1'b0; cmd_sel = '0;
    cmd_ilen = '0; cmd_dlen = '0; wd_valid = 1'b0; wd_data = '0;
    c2_valid = 1'b0; c2_bcast = 1'b0; c2_sel = '0; c2_ilen = '0; c2_dlen = '0;
    w2_valid = 1'b0; w2_data = 32'h5A5A_0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset iwe", 64'(boot_iwe), 64'h0);
    chk("reset dwe", 64'(boot_dwe), 64'h0);
    chk("reset proc_run", 64'(proc_run), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    chk("reset cmd_err", 64'(cmd_err), 64'h0);
    chk("reset iaddr", 64'(boot_iaddr), 64'h0);
    chk("reset ddata", 64'(boot_ddata), 64'h0);
    chk("reset cmd_ready", 64'(cmd_ready), 64'h1);
    reset = 1'b0;

    // Single load: sel=4, ilen=3, dlen=2
    ip0 = ipulses; dp0 = dpulses;
    do_cmd(6'd4, 1'b0, 15'd3, 15'd2);
    chk("t1 busy", 64'(busy), 64'h1);
    for (int i = 0; i < 3; i++) begin
      push(32'hA0 + 32'(i));
      chk("t1 iwe", 64'(boot_iwe), 64'h010);
      chk("t1 iaddr", 64'(boot_iaddr), 64'(i));
      chk("t1 idata", 64'(boot_idata), 64'(32'hA0 + 32'(i)));
      chk("t1 dwe idle", 64'(boot_dwe), 64'h0);
    end
    for (int i = 0; i < 2; i++) begin
      push(32'hA3 + 32'(i));
      chk("t1 dwe", 64'(boot_dwe), 64'h010);
      chk("t1 daddr", 64'(boot_daddr), 64'(i));
      chk("t1 ddata", 64'(boot_ddata), 64'(32'hA3 + 32'(i)));
    end
    wd_valid = 1'b0;
    chk("t1 run before release", 64'(proc_run), 64'h0);
    @(posedge clk); #1;
    chk("t1 done", 64'(done), 64'h1);
    chk("t1 proc_run", 64'(proc_run), 64'h010);
    chk("t1 dwe after", 64'(boot_dwe), 64'h0);
    @(posedge clk); #1;
    chk("t1 done single pulse", 64'(done), 64'h0);
    chk("t1 idle", 64'(busy), 64'h0);
    chk("t1 ipulses", 64'(ipulses - ip0), 64'd3);
    chk("t1 dpulses", 64'(dpulses - dp0), 64'd2);

    // Broadcast: ilen=1, dlen=0
    ip0 = ipulses; dp0 = dpulses;
    do_cmd(6'd0, 1'b1, 15'd1, 15'd0);
    chk("t2 run cleared", 64'(proc_run), 64'h0);
    push(32'hDEADBEEF);
    chk("t2 iwe", 64'(boot_iwe), 64'h1FF);
    chk("t2 iaddr", 64'(boot_iaddr), 64'h0);
    chk("t2 idata", 64'(boot_idata), 64'hDEADBEEF);
    wd_valid = 1'b0;
    @(posedge clk); #1;
    chk("t2 iwe one cycle", 64'(boot_iwe), 64'h0);
    chk("t2 done", 64'(done), 64'h1);
    chk("t2 proc_run", 64'(proc_run), 64'h1FF);
    chk("t2 ipulses", 64'(ipulses - ip0), 64'd1);
    chk("t2 no dwe", 64'(dpulses - dp0), 64'd0);

    // Stalled stream: sel=0, ilen=4, one idle cycle after every word
    ip0 = ipulses;
    do_cmd(6'd0, 1'b0, 15'd4, 15'd0);
    chk("t3 run bit0 dropped", 64'(proc_run), 64'h1FE);
    for (int k = 0; k < 4; k++) begin
      push(32'h100 + 32'(k));
      chk("t3 iwe", 64'(boot_iwe), 64'h001);
      chk("t3 iaddr", 64'(boot_iaddr), 64'(k));
      wd_valid = 1'b0;
      @(posedge clk); #1;
      chk("t3 stall no write", 64'(boot_iwe), 64'h0);
    end
    chk("t3 done", 64'(done), 64'h1);
    chk("t3 proc_run", 64'(proc_run), 64'h1FF);
    chk("t3 ipulses", 64'(ipulses - ip0), 64'd4);

    // Zero lengths: sel=3
    ip0 = ipulses; dp0 = dpulses;
    do_cmd(6'd3, 1'b0, 15'd0, 15'd0);
    chk("t4 run bit3 dropped", 64'(proc_run), 64'h1F7);
    chk("t4 done not yet", 64'(done), 64'h0);
    @(posedge clk); #1;
    chk("t4 done", 64'(done), 64'h1);
    chk("t4 proc_run", 64'(proc_run), 64'h1FF);
    chk("t4 no writes", 64'((ipulses - ip0) + (dpulses - dp0)), 64'd0);

    // Bad select: sel=9 on a 9-processor mesh
    ip0 = ipulses; dp0 = dpulses;
    do_cmd(6'd9, 1'b0, 15'd2, 15'd2);
    chk("t5 cmd_err", 64'(cmd_err), 64'h1);
    chk("t5 busy", 64'(busy), 64'h0);
    chk("t5 cmd_ready", 64'(cmd_ready), 64'h1);
    chk("t5 proc_run", 64'(proc_run), 64'h1FF);
    @(posedge clk); #1;
    chk("t5 cmd_err pulse", 64'(cmd_err), 64'h0);
    chk("t5 no writes", 64'((ipulses - ip0) + (dpulses - dp0)), 64'd0);

    // Reload proc 2 while the others run
    do_cmd(6'd2, 1'b0, 15'd1, 15'd0);
    chk("t6 run bit2 dropped", 64'(proc_run), 64'h1FB);
    chk("t6 run bit4 kept", 64'(proc_run[4]), 64'h1);
    push(32'h55);
    chk("t6 iwe", 64'(boot_iwe), 64'h004);
    wd_valid = 1'b0;
    wait_done();
    chk("t6 proc_run", 64'(proc_run), 64'h1FF);

    // Reset during LOAD_D, on word 1 of 4
    do_cmd(6'd1, 1'b0, 15'd0, 15'd4);
    chk("t7 run bit1 dropped", 64'(proc_run), 64'h1FD);
    push(32'hD0);
    chk("t7 dwe", 64'(boot_dwe), 64'h002);
    chk("t7 daddr", 64'(boot_daddr), 64'h0);
    wd_data = 32'hD1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t7 dwe after reset", 64'(boot_dwe), 64'h0);
    chk("t7 iwe after reset", 64'(boot_iwe), 64'h0);
    chk("t7 proc_run after reset", 64'(proc_run), 64'h0);
    chk("t7 busy after reset", 64'(busy), 64'h0);
    reset = 1'b0;
    wd_valid = 1'b0;
    do_cmd(6'd5, 1'b0, 15'd1, 15'd0);
    chk("t7 new cmd busy", 64'(busy), 64'h1);
    push(32'h77);
    chk("t7 new iwe", 64'(boot_iwe), 64'h020);
    chk("t7 new iaddr", 64'(boot_iaddr), 64'h0);
    wd_valid = 1'b0;
    wait_done();
    chk("t7 new proc_run", 64'(proc_run), 64'h020);
    chk("iwe/dwe never overlap", 64'(overlaps), 64'd0);

    // Address wrap on the ADDR_W=2 instance: ilen=5
    c2_valid = 1'b1; c2_sel = 6'd0; c2_ilen = 4'd5; c2_dlen = 4'd0;
    @(posedge clk); #1;
    c2_valid = 1'b0;
    w2_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    w2_valid = 1'b0;
    chk("t8 write count", 64'(n2), 64'd5);
    chk("t8 addr[0]", 64'(a2[0]), 64'd0);
    chk("t8 addr[3]", 64'(a2[3]), 64'd3);
    chk("t8 fifth addr wraps", 64'(a2[4]), 64'd0);
    chk("t8 proc_run", 64'(run2), 64'h001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
